// File: rtl/fcfi_pkg.sv
// Shared types and decode helpers for the forward-edge CFI landing-pad checker.
package fcfi_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LP_EXPECTED = 2'd1,
        FAULT       = 2'd2
    } lp_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_NOT_LPAD = 2'b01,
        CAUSE_LABEL    = 2'b10,
        CAUSE_MISALIGN = 2'b11
    } lp_cause_e;

    localparam logic [11:0] LPAD_LO12 = 12'h017;

    // LPAD is AUIPC x0; the low opcode bits 2'b11 also rule out compressed encodings.
    function automatic logic is_lpad(input logic [31:0] instr);
        return instr[11:0] == LPAD_LO12;
    endfunction

    // Jumps through the link registers and x7 are returns / software-guarded calls.
    function automatic logic is_exempt_rs1(input logic [4:0] idx);
        return (idx == 5'd1) || (idx == 5'd5) || (idx == 5'd7);
    endfunction

endpackage

// File: rtl/fcfi_lp_checker.sv
// Landing-pad checker: after a non-exempt indirect jump the next accepted instruction
// must be an aligned LPAD with a matching label, otherwise a sticky fault is raised.
module fcfi_lp_checker
    import fcfi_pkg::*;
#(
    parameter int unsigned VLEN    = 64,
    parameter int unsigned LABEL_W = 20,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic               flush_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [VLEN-1:0]    pc_i,
    input  logic [31:0]        instr_i,
    input  logic               rvi_jalr_i,
    input  logic               rvc_jr_i,
    input  logic               rvc_jalr_i,
    input  logic [LABEL_W-1:0] label_i,
    input  logic               fault_ack_i,
    output logic               fault_o,
    output logic [VLEN-1:0]    fault_pc_o,
    output logic [1:0]         fault_cause_o,
    output logic               elp_o,
    output logic [CNT_W-1:0]   viol_cnt_o
);

    lp_state_e          state_q, state_d;
    logic [LABEL_W-1:0] label_q, label_d;
    logic [VLEN-1:0]    fault_pc_q, fault_pc_d;
    lp_cause_e          cause_q, cause_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic      accept;
    logic      ind_jump;
    lp_cause_e check_cause;

    assign accept = valid_i & ready_o & ~flush_i;

    assign ind_jump = (rvi_jalr_i & ~is_exempt_rs1(instr_i[19:15]))
                    | ((rvc_jr_i | rvc_jalr_i) & ~is_exempt_rs1(instr_i[11:7]));

    always_comb begin
        check_cause = CAUSE_NONE;
        if (!is_lpad(instr_i)) begin
            check_cause = CAUSE_NOT_LPAD;
        end else if (pc_i[1:0] != 2'b00) begin
            check_cause = CAUSE_MISALIGN;
        end else if ((label_q != '0) && (instr_i[31:12] != label_q)) begin
            check_cause = CAUSE_LABEL;
        end
    end

    always_comb begin
        state_d    = state_q;
        label_d    = label_q;
        fault_pc_d = fault_pc_q;
        cause_d    = cause_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept && en_i && ind_jump) begin
                    state_d = LP_EXPECTED;
                    label_d = label_i;
                end
            end
            LP_EXPECTED: begin
                // Flush or disable drops the expectation without checking the instruction.
                if (flush_i || !en_i) begin
                    state_d = IDLE;
                end else if (accept) begin
                    state_d = IDLE;
                    if (check_cause != CAUSE_NONE) begin
                        state_d    = FAULT;
                        fault_pc_d = pc_i;
                        cause_d    = check_cause;
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FAULT: begin
                if (fault_ack_i) begin
                    state_d    = IDLE;
                    fault_pc_d = '0;
                    cause_d    = CAUSE_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            label_q    <= '0;
            fault_pc_q <= '0;
            cause_q    <= CAUSE_NONE;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            label_q    <= label_d;
            fault_pc_q <= fault_pc_d;
            cause_q    <= cause_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ready_o       = (state_q != FAULT);
    assign fault_o       = (state_q == FAULT);
    assign elp_o         = (state_q == LP_EXPECTED);
    assign fault_pc_o    = fault_pc_q;
    assign fault_cause_o = cause_q;
    assign viol_cnt_o    = cnt_q;

endmodule
